// File: rtl/spi_slave_rx.sv
// SPI slave receiver: deserialises mosi into an RX queue and returns a host-loaded byte on miso.
// Build option SPI_SLAVE_RX_FIFO_EN selects a FIFO_DEPTH-entry RX FIFO; otherwise a single holding register.
module spi_slave_rx #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] TX_IDLE    = 8'hFF
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              overrun,
  output logic              underrun,
  output logic              frame_err,
  input  logic              clr_err
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-2:0]   rx_shift;
  logic [DATA_W-1:0]   tx_shift;
  logic [DATA_W-1:0]   tx_buf;
  logic                tx_fresh;
  logic [DATA_W-1:0]   rx_byte;
  logic [DATA_W-1:0]   slot_byte;
  logic                shifting, slot_start, byte_done, frame_abort;
  logic                pop, drop;

  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = ss ? IDLE : SHIFT;
  end

  always_comb begin
    shifting    = 1'b0;
    slot_start  = 1'b0;
    byte_done   = 1'b0;
    frame_abort = 1'b0;
    case (state_reg)
      IDLE: begin
        shifting   = !ss;
        slot_start = !ss;
      end
      SHIFT: begin
        if (!ss) begin
          shifting   = 1'b1;
          byte_done  = (bit_cnt == LAST_BIT);
          slot_start = (bit_cnt == LAST_BIT);
        end else begin
          frame_abort = (bit_cnt != '0);
        end
      end
      default: ;
    endcase
  end

  assign rx_byte   = {rx_shift, mosi};
  assign slot_byte = tx_fresh ? tx_buf : TX_IDLE;
  assign miso      = ss ? 1'b0 : tx_shift[DATA_W-1];

  // The idle preload tracks tx_load so the first bit of a frame matches the slot-start decision.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_buf   <= TX_IDLE;
      tx_fresh <= 1'b0;
    end else begin
      if (shifting) begin
        rx_shift <= rx_byte[DATA_W-2:0];
        bit_cnt  <= byte_done ? '0 : bit_cnt + 1'b1;
        tx_shift <= byte_done ? slot_byte : {tx_shift[DATA_W-2:0], 1'b0};
      end else begin
        bit_cnt  <= '0;
        tx_shift <= tx_load ? tx_data : slot_byte;
      end
      if (tx_load) begin
        tx_buf   <= tx_data;
        tx_fresh <= 1'b1;
      end else if (slot_start) begin
        tx_fresh <= 1'b0;
      end
    end
  end

  // Sticky error flags: a new event on the same edge as clr_err wins.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop)                       overrun <= 1'b1;
      else if (clr_err)               overrun <= 1'b0;
      if (slot_start && !tx_fresh)    underrun <= 1'b1;
      else if (clr_err)               underrun <= 1'b0;
      if (frame_abort)                frame_err <= 1'b1;
      else if (clr_err)               frame_err <= 1'b0;
    end
  end

  assign pop = rx_valid && rx_ready;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int QC_W  = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
  logic [QC_W-1:0]   count;
  logic              full, push;

  assign full       = (count == QC_W'(FIFO_DEPTH));
  assign push       = byte_done && (!full || pop);
  assign drop       = byte_done && full && !pop;
  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign rx_valid   = (count != '0);

  always_ff @(posedge global_clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  // rx_data is a registered copy of the head so it holds its value once the FIFO drains.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && (count == '0 || (pop && count == QC_W'(1))))
        rx_data <= rx_byte;
      else if (pop && count > QC_W'(1))
        rx_data <= mem[rd_ptr_inc];
    end
  end
`else
  logic hold_valid;
  logic push;

  assign push     = byte_done && (!hold_valid || pop);
  assign drop     = byte_done && hold_valid && !pop;
  assign rx_valid = hold_valid;

  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      rx_data    <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      rx_data    <= rx_byte;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

endmodule
